io_port_unit: RTL
=================

// Module: io_port_unit
// PURPOSE
//  Edge stage between the bus datapath and external devices. The in instruction reads a
//  4-deep device input FIFO through inport_q (Inportout). The out instruction loads the
//  output register (OutPortin) and the block presents it to the device on valid/ack.
//  Sits directly beside the bus: consumes bus_data/OutPortin, produces inport_q.
// PARAMETERS
//  WIDTH    32  data width of the bus and both ports
//  IN_DEPTH 4   input FIFO entries; must be a power of 2
//  ADDR_W   2   log2(IN_DEPTH)
// PORTS
//  clock        in   1      single system clock; all state changes on its rising edge
//  clear        in   1      asynchronous, active-low reset
//  in_data      in   WIDTH  device input word
//  in_valid     in   1      device offers in_data
//  in_ready     out  1      FIFO accepts the word; = !full
//  in_pop       in   1      CPU consumes the FIFO head. One pulse per in instruction,
//                           asserted in the cycle the control unit asserts Inportout.
//  inport_q     out  WIDTH  FIFO head, combinational; 0 when empty
//  in_avail     out  1      FIFO not empty
//  OutPortin    in   1      load bus_data into the output register
//  bus_data     in   WIDTH  bus value
//  out_data     out  WIDTH  output register
//  out_valid    out  1      out_data pending for the device
//  out_ack      in   1      device accepted out_data
//  err_clr      in   1      clears both sticky error flags
//  in_underflow out  1      sticky: in_pop was asserted while the FIFO was empty
//  out_overrun  out  1      sticky: pending output data was overwritten before ack
// BEHAVIOUR
//  - Reset (clear=0, any time, even mid-transfer):
//    pointers=0, count=0, out_data=0, out_valid=0, both flags=0, state=IDLE.
//    Reset takes effect immediately, without a clock edge.
//  - FIFO push: on an edge with in_valid && in_ready.
//    Pop: on an edge with in_pop && !empty. Both have 1-cycle latency.
//  - count is ADDR_W+1 bits wide. Both pointers wrap modulo IN_DEPTH.
//    full = (count == IN_DEPTH); empty = (count == 0).
//  - Push and pop on the same edge while non-empty: count unchanged, head advances.
//  - in_pop while empty: no pointer change, in_underflow<=1. This includes the edge on
//    which a push lands into the empty FIFO: the push is kept and the pop is ignored.
//  - Full: in_ready=0, so a push is never accepted in the same edge as a pop.
//  - Output FSM has two states:
//    IDLE: out_valid=0. OutPortin -> out_data<=bus_data, go to HOLD.
//    HOLD: out_valid=1.
//      out_ack && !OutPortin -> IDLE.
//      out_ack && OutPortin  -> load new data, stay HOLD, no overrun.
//      !out_ack && OutPortin -> replace data, stay HOLD, out_overrun<=1.
//    out_ack while in IDLE is ignored.
//  - err_clr clears both flags. It wins over a same-edge set.
// CONFIGURATION
//  IO_PORT_LOOPBACK_EN defined:
//    - Adds input port `loopback` (1 bit).
//    - While loopback=1: in_ready=0; the FSM stays IDLE and out_valid=0; each OutPortin
//      edge pushes bus_data into the FIFO (dropped if full; out_data still updates).
//    - While loopback=0: behaviour is identical to the undefined case.
//  IO_PORT_LOOPBACK_EN undefined: no loopback port; normal device paths only.
// TESTING
//  1. clear=0 mid-HOLD with 3 FIFO words
//     -> out_valid=0, in_avail=0, inport_q=0 at once.
//  2. Push 0xA,0xB,0xC,0xD -> in_ready=0. Pop x4 -> inport_q shows 0xA..0xD in order,
//     then in_avail=0.
//  3. Push 5 words and pop 5 (steady state) -> pointers wrap, order preserved, count ok.
//  4. Pop on empty with push of 0x55 on the same edge
//     -> in_underflow=1, inport_q=0x55 next cycle.
//  5. OutPortin bus=0x1234, no ack, OutPortin bus=0x5678 -> out_data=0x5678,
//     out_overrun=1. Ack -> out_valid=0. err_clr -> flag=0.
//  6. LOOPBACK_EN with loopback=1, OutPortin 0x99
//     -> out_valid stays 0, in_avail=1, inport_q=0x99.

Source files
------------

// File: rtl/io_port_if.sv
// Bus/device-side signal bundle for io_port_unit: input FIFO, output register, error flags.
// The unit takes the slave modport; the driving side (bus/control/device model) takes master.
interface io_port_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             in_pop;
    logic [WIDTH-1:0] inport_q;
    logic             in_avail;
    logic             OutPortin;
    logic [WIDTH-1:0] bus_data;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ack;
    logic             err_clr;
    logic             in_underflow;
    logic             out_overrun;

    modport slave (
        input  in_data, in_valid, in_pop, OutPortin, bus_data, out_ack, err_clr,
        output in_ready, inport_q, in_avail, out_data, out_valid, in_underflow, out_overrun
    );

    modport master (
        output in_data, in_valid, in_pop, OutPortin, bus_data, out_ack, err_clr,
        input  in_ready, inport_q, in_avail, out_data, out_valid, in_underflow, out_overrun
    );
endinterface

// File: rtl/io_port_unit.sv
// I/O edge stage: device input FIFO read by the in instruction, output register with valid/ack.
// Optional IO_PORT_LOOPBACK_EN adds a `loopback` port that routes OutPortin writes into the FIFO.
module io_port_unit #(
    parameter int WIDTH    = 32,
    parameter int IN_DEPTH = 4,
    parameter int ADDR_W   = 2
) (
    input  logic       clock,
    input  logic       clear,
`ifdef IO_PORT_LOOPBACK_EN
    input  logic       loopback,
`endif
    io_port_if.slave   io
);
    typedef enum logic {IDLE, HOLD} out_state_t;

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(IN_DEPTH);

    logic [WIDTH-1:0]  mem [IN_DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   count;
    logic              full, empty, lb;
    logic              push, pop;
    logic [WIDTH-1:0]  push_data;
    out_state_t        state, next_state;
    logic              load_out, set_overrun;

`ifdef IO_PORT_LOOPBACK_EN
    assign lb = loopback;
`else
    assign lb = 1'b0;
`endif

    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);

    assign io.in_ready = !full && !lb;
    assign io.in_avail = !empty;
    assign io.inport_q = empty ? '0 : mem[rd_ptr];

    // Loopback writes take the FIFO push slot; the device side is blocked meanwhile.
    assign push      = lb ? (io.OutPortin && !full) : (io.in_valid && io.in_ready);
    assign push_data = lb ? io.bus_data : io.in_data;
    assign pop       = io.in_pop && !empty;

    // NOTE: storage has no reset; only pointers/count define validity, and an empty FIFO reads 0.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (ADDR_W+1)'(1);
                2'b01:   count <= count - (ADDR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state       <= IDLE;
            io.out_data <= '0;
        end else begin
            state <= next_state;
            if (load_out) io.out_data <= io.bus_data;
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        next_state   = state;
        load_out     = 1'b0;
        set_overrun  = 1'b0;
        io.out_valid = 1'b0;
        if (lb) begin
            next_state = IDLE;
            load_out   = io.OutPortin;
        end else begin
            case (state)
                IDLE: begin
                    if (io.OutPortin) begin
                        load_out   = 1'b1;
                        next_state = HOLD;
                    end
                end
                HOLD: begin
                    io.out_valid = 1'b1;
                    if (io.OutPortin) begin
                        load_out    = 1'b1;
                        set_overrun = !io.out_ack;
                    end else if (io.out_ack) begin
                        next_state = IDLE;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // Clear has priority over a set arriving on the same edge.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            io.in_underflow <= 1'b0;
            io.out_overrun  <= 1'b0;
        end else if (io.err_clr) begin
            io.in_underflow <= 1'b0;
            io.out_overrun  <= 1'b0;
        end else begin
            if (io.in_pop && empty) io.in_underflow <= 1'b1;
            if (set_overrun)        io.out_overrun  <= 1'b1;
        end
    end
endmodule
